ad_serial_rx: RTL and testbench

//  FPGA-side receiver for the dual-channel serial ADC (X/Y). Drives the ADC convert/load

---
 rtl/ad_serial_rx.sv | 145 ++++++++++++++
 tb/tb_ad_serial_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_serial_rx.sv
// Dual-channel serial ADC receiver: drives convert strobe and bit clock, deserialises
// the X/Y MSB-first data lines into parallel words with a one-cycle valid pulse.
module ad_serial_rx #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CONV_CYC = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              cont_i,
   output logic              ad_conv_o,
   output logic              ad_sclk_o,
   input  logic              ad_sd_x_i,
   input  logic              ad_sd_y_i,
   output logic [DATA_W-1:0] vx_o,
   output logic [DATA_W-1:0] vy_o,
   output logic              data_vld_o,
   output logic              busy_o,
   output logic              missed_start_o
);

   localparam int unsigned HALF    = CLK_DIV / 2;
   localparam int unsigned CNT_MAX = (CLK_DIV > CONV_CYC) ? CLK_DIV : CONV_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_GAP, S_SHIFT} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [BIT_W-1:0]    r_bit_cnt, w_bit_nxt;
   logic                r_conv, w_conv_nxt;
   logic                r_sclk, w_sclk_nxt;
   logic [DATA_W-2:0]   r_sx, w_sx_nxt;
   logic [DATA_W-2:0]   r_sy, w_sy_nxt;
   logic [DATA_W-1:0]   r_vx, w_vx_nxt;
   logic [DATA_W-1:0]   r_vy, w_vy_nxt;
   logic                r_vld, w_vld_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_missed, w_missed_nxt;

   logic                w_fall;
   logic                w_period_end;
   logic                w_done;
   logic [DATA_W-1:0]   w_word_x;
   logic [DATA_W-1:0]   w_word_y;

   // Capture happens on the SCLK falling edge, half a period after the ADC shifted out.
   assign w_fall       = (r_state == S_SHIFT) && r_sclk && (r_cnt == CNT_W'(HALF - 1));
   assign w_period_end = (r_state == S_SHIFT) && (r_cnt == CNT_W'(CLK_DIV - 1));
   assign w_done       = w_fall && (r_bit_cnt == BIT_W'(DATA_W - 1));
   assign w_word_x     = {r_sx, ad_sd_x_i};
   assign w_word_y     = {r_sy, ad_sd_y_i};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nxt = S_CONV;
         S_CONV:  if (r_cnt == CNT_W'(CONV_CYC - 1)) w_state_nxt = S_GAP;
         S_GAP:   if (r_cnt == CNT_W'(HALF - 1)) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_done) w_state_nxt = (cont_i || start_i) ? S_CONV : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_nxt    = r_cnt + CNT_W'(1);
      w_bit_nxt    = r_bit_cnt;
      w_sclk_nxt   = r_sclk;
      w_sx_nxt     = r_sx;
      w_sy_nxt     = r_sy;
      w_vx_nxt     = r_vx;
      w_vy_nxt     = r_vy;
      w_conv_nxt   = (w_state_nxt == S_CONV);
      w_busy_nxt   = (w_state_nxt != S_IDLE);
      w_vld_nxt    = w_done;
      w_missed_nxt = start_i && (r_state != S_IDLE) && !w_done;

      if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) w_cnt_nxt = '0;

      if (w_state_nxt != S_SHIFT)  w_sclk_nxt = 1'b0;
      else if (r_state == S_GAP)   w_sclk_nxt = 1'b1;

      if (w_fall) begin
         w_sclk_nxt = 1'b0;
         w_sx_nxt   = w_word_x[DATA_W-2:0];
         w_sy_nxt   = w_word_y[DATA_W-2:0];
         w_bit_nxt  = w_done ? '0 : r_bit_cnt + BIT_W'(1);
      end

      if (w_period_end) begin
         w_sclk_nxt = 1'b1;
         w_cnt_nxt  = '0;
      end

      // Only complete words ever reach the outputs.
      if (w_done) begin
         w_vx_nxt = w_word_x;
         w_vy_nxt = w_word_y;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_conv    <= 1'b0;
         r_sclk    <= 1'b0;
         r_sx      <= '0;
         r_sy      <= '0;
         r_vx      <= '0;
         r_vy      <= '0;
         r_vld     <= 1'b0;
         r_busy    <= 1'b0;
         r_missed  <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_conv    <= w_conv_nxt;
         r_sclk    <= w_sclk_nxt;
         r_sx      <= w_sx_nxt;
         r_sy      <= w_sy_nxt;
         r_vx      <= w_vx_nxt;
         r_vy      <= w_vy_nxt;
         r_vld     <= w_vld_nxt;
         r_busy    <= w_busy_nxt;
         r_missed  <= w_missed_nxt;
      end
   end

   assign ad_conv_o      = r_conv;
   assign ad_sclk_o      = r_sclk;
   assign vx_o           = r_vx;
   assign vy_o           = r_vy;
   assign data_vld_o     = r_vld;
   assign busy_o         = r_busy;
   assign missed_start_o = r_missed;

endmodule

// File: tb/tb_ad_serial_rx.sv
// Bench for ad_serial_rx: behavioural ADC models drive both data lines from the
// convert strobe and bit clock; results are checked against hand-computed tables.
module tb_ad_serial_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Default-parameter instance
   logic start0 = 1'b0, cont0 = 1'b0, sdx0 = 1'b0, sdy0 = 1'b0;
   logic conv0, sclk0, vld0, busy0, miss0;
   logic [15:0] vx0, vy0;

   ad_serial_rx dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .cont_i(cont0),
      .ad_conv_o(conv0), .ad_sclk_o(sclk0), .ad_sd_x_i(sdx0), .ad_sd_y_i(sdy0),
      .vx_o(vx0), .vy_o(vy0), .data_vld_o(vld0), .busy_o(busy0), .missed_start_o(miss0));

   // Slow-SCLK instance
   logic start1 = 1'b0, cont1 = 1'b0, sdx1 = 1'b0, sdy1 = 1'b0;
   logic conv1, sclk1, vld1, busy1, miss1;
   logic [15:0] vx1, vy1;

   ad_serial_rx #(.DATA_W(16), .CLK_DIV(8), .CONV_CYC(2)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .cont_i(cont1),
      .ad_conv_o(conv1), .ad_sclk_o(sclk1), .ad_sd_x_i(sdx1), .ad_sd_y_i(sdy1),
      .vx_o(vx1), .vy_o(vy1), .data_vld_o(vld1), .busy_o(busy1), .missed_start_o(miss1));

   // ADC model 0: loads a word per conversion, shifts MSB out on each SCLK rise
   logic [15:0] x_tab0 [4];
   logic [15:0] y_tab0 [4];
   int conv_base0 = 0;
   int conv_cnt0 = 0, rise_cnt0 = 0;
   logic [15:0] shx0 = '0, shy0 = '0;
   always @(posedge conv0) begin
      shx0 = x_tab0[(conv_cnt0 - conv_base0) & 3];
      shy0 = y_tab0[(conv_cnt0 - conv_base0) & 3];
      conv_cnt0++;
   end
   always @(posedge sclk0) begin
      sdx0 = shx0[15];
      sdy0 = shy0[15];
      shx0 = shx0 << 1;
      shy0 = shy0 << 1;
      rise_cnt0++;
   end

   logic [15:0] x_word1 = '0, y_word1 = '0;
   logic [15:0] shx1 = '0, shy1 = '0;
   int rise_cnt1 = 0;
   always @(posedge conv1) begin
      shx1 = x_word1;
      shy1 = y_word1;
   end
   always @(posedge sclk1) begin
      sdx1 = shx1[15];
      sdy1 = shy1[15];
      shx1 = shx1 << 1;
      shy1 = shy1 << 1;
      rise_cnt1++;
   end

   // Event log for instance 0, sampled on the falling clock edge
   int vld_cnt0 = 0, miss_cnt0 = 0;
   int vld_edge_q[$];
   int conv_edge_q[$];
   logic [15:0] vx_q[$], vy_q[$];
   logic conv0_d = 1'b0;
   always @(negedge clk) begin
      if (vld0) begin
         vld_cnt0++;
         vld_edge_q.push_back(edge_cnt);
         vx_q.push_back(vx0);
         vy_q.push_back(vy0);
      end
      if (miss0) miss_cnt0++;
      if (conv0 && !conv0_d) conv_edge_q.push_back(edge_cnt);
      conv0_d = conv0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input int which, output int e0);
      @(posedge clk); #1;
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      e0 = edge_cnt;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_vld0(input int target, input int budget, input string name);
      int n = 0;
      while (vld_cnt0 < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (vld_cnt0 < target) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, valid count %0d required %0d", name, vld_cnt0, target);
      end
   endtask

   typedef struct {
      logic [15:0] adc_x;
      logic [15:0] adc_y;
      logic [15:0] exp_x;
      logic [15:0] exp_y;
      int          exp_lat;
      int          exp_rises;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int e0, vb, rb, cb, ce, mb, hi_run, run, nrise, bad_hi, bad_lo, vld1_edge;
      logic p;
      logic [15:0] vx1_cap, vy1_cap;

      vecs[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A, 68, 16};
      vecs[1] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 68, 16};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 68, 16};
      vecs[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 68, 16};
      vecs[4] = '{16'h1234, 16'hEDCB, 16'h1234, 16'hEDCB, 68, 16};
      for (int i = 0; i < 4; i++) begin
         x_tab0[i] = '0;
         y_tab0[i] = '0;
      end

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_conv0", 32'(conv0), 0);
      chk("rst_sclk0", 32'(sclk0), 0);
      chk("rst_vx0", 32'(vx0), 0);
      chk("rst_vy0", 32'(vy0), 0);
      chk("rst_vld0", 32'(vld0), 0);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_miss0", 32'(miss0), 0);
      chk("rst_sclk1", 32'(sclk1), 0);
      chk("rst_busy1", 32'(busy1), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single conversions from the vector table
      for (int i = 0; i < 5; i++) begin
         conv_base0 = conv_cnt0;
         x_tab0[0] = vecs[i].adc_x;
         y_tab0[0] = vecs[i].adc_y;
         vb = vld_cnt0; rb = rise_cnt0; mb = miss_cnt0;
         pulse_start(0, e0);
         #1 chk($sformatf("v%0d_busy_start", i), 32'(busy0), 1);
         wait_vld0(vb + 1, 120, $sformatf("v%0d_wait", i));
         if (vld_cnt0 > vb) begin
            chk($sformatf("v%0d_lat", i), 32'(vld_edge_q[vb] - e0), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_vx", i), 32'(vx_q[vb]), 32'(vecs[i].exp_x));
            chk($sformatf("v%0d_vy", i), 32'(vy_q[vb]), 32'(vecs[i].exp_y));
         end
         chk($sformatf("v%0d_busy_done", i), 32'(busy0), 0);
         repeat (6) @(negedge clk);
         chk($sformatf("v%0d_rises", i), 32'(rise_cnt0 - rb), 32'(vecs[i].exp_rises));
         chk($sformatf("v%0d_hold_vx", i), 32'(vx0), 32'(vecs[i].exp_x));
         chk($sformatf("v%0d_one_vld", i), 32'(vld_cnt0 - vb), 1);
         chk($sformatf("v%0d_no_miss", i), 32'(miss_cnt0 - mb), 0);
      end

      // Start request while busy is dropped
      conv_base0 = conv_cnt0;
      x_tab0[0] = 16'h5A5A; y_tab0[0] = 16'hC001;
      vb = vld_cnt0; mb = miss_cnt0; cb = conv_cnt0;
      pulse_start(0, e0);
      repeat (19) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      wait_vld0(vb + 1, 120, "miss_wait");
      repeat (10) @(negedge clk);
      chk("miss_pulses", 32'(miss_cnt0 - mb), 1);
      chk("miss_conv_once", 32'(conv_cnt0 - cb), 1);
      chk("miss_one_vld", 32'(vld_cnt0 - vb), 1);
      chk("miss_vx", 32'(vx0), 32'h5A5A);
      chk("miss_vy", 32'(vy0), 32'hC001);

      // Continuous mode, three conversions back to back
      conv_base0 = conv_cnt0;
      x_tab0[0] = 16'h1111; y_tab0[0] = 16'hEEEE;
      x_tab0[1] = 16'h2468; y_tab0[1] = 16'h1357;
      x_tab0[2] = 16'hF00D; y_tab0[2] = 16'h0BAD;
      vb = vld_cnt0; cb = conv_cnt0; ce = conv_edge_q.size();
      cont0 = 1'b1;
      pulse_start(0, e0);
      wait_vld0(vb + 2, 200, "cont_wait2");
      cont0 = 1'b0;
      wait_vld0(vb + 3, 100, "cont_wait3");
      repeat (6) @(negedge clk);
      if (vld_cnt0 >= vb + 3 && conv_edge_q.size() >= ce + 3) begin
         chk("cont_lat0", 32'(vld_edge_q[vb] - e0), 68);
         chk("cont_per1", 32'(vld_edge_q[vb+1] - vld_edge_q[vb]), 68);
         chk("cont_per2", 32'(vld_edge_q[vb+2] - vld_edge_q[vb+1]), 68);
         chk("cont_vx0", 32'(vx_q[vb]), 32'h1111);
         chk("cont_vy0", 32'(vy_q[vb]), 32'hEEEE);
         chk("cont_vx1", 32'(vx_q[vb+1]), 32'h2468);
         chk("cont_vy1", 32'(vy_q[vb+1]), 32'h1357);
         chk("cont_vx2", 32'(vx_q[vb+2]), 32'hF00D);
         chk("cont_vy2", 32'(vy_q[vb+2]), 32'h0BAD);
         chk("cont_conv_e0", 32'(conv_edge_q[ce]), 32'(e0));
         chk("cont_conv_re1", 32'(conv_edge_q[ce+1]), 32'(vld_edge_q[vb]));
         chk("cont_conv_re2", 32'(conv_edge_q[ce+2]), 32'(vld_edge_q[vb+1]));
      end else begin
         chk("cont_events", 32'(vld_cnt0 - vb), 3);
      end
      chk("cont_convs", 32'(conv_cnt0 - cb), 3);
      chk("cont_idle", 32'(busy0), 0);

      // Reset in the middle of a conversion
      conv_base0 = conv_cnt0;
      x_tab0[0] = 16'h0F0F; y_tab0[0] = 16'hF0F0;
      vb = vld_cnt0; rb = rise_cnt0;
      pulse_start(0, e0);
      repeat (36) @(posedge clk);
      #1;
      chk("rstmid_rises", 32'(rise_cnt0 - rb), 8);
      rst_n = 1'b0;
      #1;
      chk("rstmid_conv", 32'(conv0), 0);
      chk("rstmid_sclk", 32'(sclk0), 0);
      chk("rstmid_vx", 32'(vx0), 0);
      chk("rstmid_vy", 32'(vy0), 0);
      chk("rstmid_vld", 32'(vld0), 0);
      chk("rstmid_busy", 32'(busy0), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("rstmid_no_vld", 32'(vld_cnt0 - vb), 0);
      conv_base0 = conv_cnt0;
      x_tab0[0] = 16'hC3A5; y_tab0[0] = 16'h5A3C;
      pulse_start(0, e0);
      wait_vld0(vb + 1, 120, "rstmid_wait");
      if (vld_cnt0 > vb) begin
         chk("rstmid_lat", 32'(vld_edge_q[vb] - e0), 68);
         chk("rstmid_vx_after", 32'(vx_q[vb]), 32'hC3A5);
         chk("rstmid_vy_after", 32'(vy_q[vb]), 32'h5A3C);
      end

      // Slow SCLK instance: CLK_DIV=8, CONV_CYC=2
      x_word1 = 16'h1234; y_word1 = 16'hFEDC;
      rb = rise_cnt1;
      hi_run = 0; run = 0; nrise = 0; bad_hi = 0; bad_lo = 0; vld1_edge = -1;
      p = 1'b0; vx1_cap = '0; vy1_cap = '0;
      pulse_start(1, e0);
      for (int c = 0; c < 300 && vld1_edge < 0; c++) begin
         @(negedge clk);
         if (vld1) begin
            vld1_edge = edge_cnt;
            vx1_cap = vx1;
            vy1_cap = vy1;
         end
         if (sclk1 == p) run++;
         else begin
            if (p && run != 4) bad_hi++;
            if (!p && nrise > 0 && run != 4) bad_lo++;
            if (sclk1) nrise++;
            run = 1;
         end
         p = sclk1;
      end
      hi_run = nrise;
      chk("slow_lat", 32'(vld1_edge - e0), 130);
      chk("slow_vx", 32'(vx1_cap), 32'h1234);
      chk("slow_vy", 32'(vy1_cap), 32'hFEDC);
      chk("slow_rises", 32'(hi_run), 16);
      chk("slow_model_rises", 32'(rise_cnt1 - rb), 16);
      chk("slow_hi_len", 32'(bad_hi), 0);
      chk("slow_lo_len", 32'(bad_lo), 0);
      repeat (3) @(negedge clk);
      chk("slow_idle", 32'(busy1), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
